// File: rtl/reduce_pkg.sv
// Shared constants for the multi-cycle bit-reduction unit.
// Mode encodings and FSM state encoding.
package reduce_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_NOR = 2'b00;
    localparam mode_t MODE_OR  = 2'b01;
    localparam mode_t MODE_AND = 2'b10;
    localparam mode_t MODE_XOR = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic acc_init(input mode_t mode);
        return (mode == MODE_AND);
    endfunction

endpackage

// File: rtl/chunk_reduce.sv
// One CHUNK-wide slice of the reduction: folds the chunk into the
// accumulator and reports the chunk's leading-zero count.
module chunk_reduce
    import reduce_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0]           bits,
    input  logic [1:0]                 mode,
    input  logic                       acc_in,
    output logic                       acc_out,
    output logic [$clog2(CHUNK+1)-1:0] lzc,
    output logic                       has_one
);

    localparam int CW = $clog2(CHUNK+1);

    logic found;

    always_comb begin
        acc_out = acc_in;
        unique case (mode)
            MODE_NOR: acc_out = acc_in | (|bits);
            MODE_OR:  acc_out = acc_in | (|bits);
            MODE_AND: acc_out = acc_in & (&bits);
            MODE_XOR: acc_out = acc_in ^ (^bits);
            default:  acc_out = acc_in;
        endcase
    end

    always_comb begin
        lzc   = '0;
        found = 1'b0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (!found) begin
                if (bits[i]) found = 1'b1;
                else         lzc   = lzc + CW'(1);
            end
        end
    end

    assign has_one = |bits;

endmodule

// File: rtl/reduce_unit_seq.sv
// Multi-cycle NOR/OR/AND/XOR reduction, CHUNK bits per cycle.
// Optional leading-zero count enabled by REDUCE_UNIT_LZC_EN.
module reduce_unit_seq
    import reduce_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [1:0]                 in_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_bit,
    output logic [$clog2(WIDTH+1)-1:0] out_lzc
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int LW     = $clog2(WIDTH+1);
    localparam int CW     = $clog2(CHUNK+1);
    localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    logic [1:0]       state;
    logic [WIDTH-1:0] sh;
    logic [1:0]       mode;
    logic             acc;
    logic [CNTW-1:0]  cnt;

    logic             acc_nx;
    logic [CW-1:0]    c_lzc;
    logic             c_one;
    logic             last;

    assign last     = (cnt == CNTW'(NCHUNK - 1));
    assign in_ready = (state == ST_IDLE);

    chunk_reduce #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .bits    (sh[WIDTH-1 -: CHUNK]),
        .mode    (mode),
        .acc_in  (acc),
        .acc_out (acc_nx),
        .lzc     (c_lzc),
        .has_one (c_one)
    );

    // DONE spends its first cycle registering the result, then holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sh        <= '0;
            mode      <= MODE_NOR;
            acc       <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
        end else if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sh    <= in_a;
                        mode  <= in_mode;
                        acc   <= acc_init(in_mode);
                        cnt   <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    sh  <= sh << CHUNK;
                    acc <= acc_nx;
                    cnt <= cnt + CNTW'(1);
                    if (last) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_bit   <= (mode == MODE_NOR) ? ~acc : acc;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef REDUCE_UNIT_LZC_EN
    logic [LW-1:0] lzc_acc;
    logic          seen;
    logic [LW-1:0] lzc_q;

    // Counting freezes at the first chunk containing a one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lzc_acc <= '0;
            seen    <= 1'b0;
            lzc_q   <= '0;
        end else if (!flush) begin
            if (state == ST_IDLE && in_valid) begin
                lzc_acc <= '0;
                seen    <= 1'b0;
            end else if (state == ST_BUSY) begin
                if (!seen) lzc_acc <= lzc_acc + LW'(c_lzc);
                seen <= seen | c_one;
            end else if (state == ST_DONE && !out_valid) begin
                lzc_q <= lzc_acc;
            end
        end
    end

    assign out_lzc = lzc_q;
`else
    logic unused_lzc;
    assign unused_lzc = ^{c_lzc, c_one};
    assign out_lzc    = '0;
`endif

endmodule

// File: tb/tb_reduce_unit_seq.sv
// Scoreboard bench for reduce_unit_seq: 32/8 and 64/16 instances.
// Define REDUCE_UNIT_LZC_EN to also check leading-zero counts.
module tb_reduce_unit_seq;
    import reduce_pkg::*;

    typedef struct {
        logic b;
        int   lzc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic        out_bit;
    logic [5:0]  out_lzc;

    logic        w_flush;
    logic        w_in_valid;
    logic        w_in_ready;
    logic [63:0] w_in_a;
    logic [1:0]  w_in_mode;
    logic        w_out_valid;
    logic        w_out_ready;
    logic        w_out_bit;
    logic [6:0]  w_out_lzc;

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    reduce_unit_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_lzc   (out_lzc)
    );

    reduce_unit_seq #(.WIDTH(64), .CHUNK(16)) dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (w_flush),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_a      (w_in_a),
        .in_mode   (w_in_mode),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_bit   (w_out_bit),
        .out_lzc   (w_out_lzc)
    );

    function automatic logic model_bit(input logic [1:0] m,
                                       input logic [63:0] a, input int w);
        logic any_b = 1'b0;
        logic all_b = 1'b1;
        logic par   = 1'b0;
        for (int i = 0; i < w; i++) begin
            any_b = any_b | a[i];
            all_b = all_b & a[i];
            par   = par ^ a[i];
        end
        case (m)
            MODE_NOR: return ~any_b;
            MODE_OR:  return any_b;
            MODE_AND: return all_b;
            default:  return par;
        endcase
    endfunction

    function automatic int model_lzc(input logic [63:0] a, input int w);
`ifdef REDUCE_UNIT_LZC_EN
        int n = 0;
        for (int i = w - 1; i >= 0; i--) begin
            if (a[i]) return n;
            n++;
        end
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic run_op(input logic [1:0] m, input logic [31:0] a,
                          input string name);
        exp_t e;
        int   n;
        @(negedge clk);
        in_a     = a;
        in_mode  = m;
        in_valid = 1'b1;
        e.b   = model_bit(m, {32'h0, a}, 32);
        e.lzc = model_lzc({32'h0, a}, 32);
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_mode  = 2'($urandom);
        n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        vectors++;
        if (out_valid !== 1'b1) begin
            $display("FAIL %s timeout: out_valid=%b want 1", name, out_valid);
            miscompares++;
        end else begin
            if (n !== 6) begin
                $display("FAIL %s latency: got %0d want 6", name, n);
                miscompares++;
            end
            vectors++;
            if (out_bit !== e.b) begin
                $display("FAIL %s out_bit: got %b want %b", name, out_bit, e.b);
                miscompares++;
            end
            vectors++;
            if (int'(out_lzc) !== e.lzc) begin
                $display("FAIL %s out_lzc: got %0d want %0d", name,
                         out_lzc, e.lzc);
                miscompares++;
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL %s release: valid=%b ready=%b want 0 1", name,
                     out_valid, in_ready);
            miscompares++;
        end
    endtask

    task automatic run_wide(input logic [1:0] m, input logic [63:0] a,
                            input string name);
        exp_t e;
        int   n;
        @(negedge clk);
        w_in_a     = a;
        w_in_mode  = m;
        w_in_valid = 1'b1;
        e.b   = model_bit(m, a, 64);
        e.lzc = model_lzc(a, 64);
        sb.push_back(e);
        @(negedge clk);
        w_in_valid = 1'b0;
        n = 1;
        while (!w_out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        vectors++;
        if (w_out_valid !== 1'b1 || n !== 6) begin
            $display("FAIL %s valid/latency: valid=%b cycles=%0d want 1 6",
                     name, w_out_valid, n);
            miscompares++;
        end
        vectors++;
        if (w_out_bit !== e.b || int'(w_out_lzc) !== e.lzc) begin
            $display("FAIL %s result: bit=%b lzc=%0d want %b %0d", name,
                     w_out_bit, w_out_lzc, e.b, e.lzc);
            miscompares++;
        end
        w_out_ready = 1'b1;
        @(negedge clk);
        w_out_ready = 1'b0;
        vectors++;
        if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1) begin
            $display("FAIL %s release: valid=%b ready=%b want 0 1", name,
                     w_out_valid, w_in_ready);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({in_ready, out_valid, out_bit, out_lzc} !== {3'b100, 6'd0}) begin
            $display("FAIL reset: rdy=%b vld=%b bit=%b lzc=%0d want 1 0 0 0",
                     in_ready, out_valid, out_bit, out_lzc);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_modes();
        run_op(MODE_NOR, 32'h0000_0000, "nor_zero");
        run_op(MODE_NOR, 32'h0001_0000, "nor_bit16");
        run_op(MODE_OR,  32'h0001_0000, "or_bit16");
        run_op(MODE_AND, 32'hFFFF_FFFF, "and_ones");
        run_op(MODE_AND, 32'hFFFF_FFFE, "and_lsb0");
        run_op(MODE_XOR, 32'h0000_0007, "xor_7");
        run_op(MODE_OR,  32'h0000_0000, "or_zero");
        run_op(MODE_NOR, 32'h8000_0000, "nor_msb");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            run_op(2'($urandom), $urandom, "b2b");
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   n;
        @(negedge clk);
        in_a     = 32'hFFFF_FFFF;
        in_mode  = MODE_AND;
        in_valid = 1'b1;
        e.b   = model_bit(MODE_AND, 64'h0000_0000_FFFF_FFFF, 32);
        e.lzc = 0;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        in_valid = 1'b1;
        in_a     = 32'h0;
        in_mode  = MODE_NOR;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if ({out_valid, out_bit, in_ready} !== {1'b1, e.b, 1'b0}) begin
                $display("FAIL bp hold %0d: vld=%b bit=%b rdy=%b want 1 %b 0",
                         i, out_valid, out_bit, in_ready, e.b);
                miscompares++;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL bp release: vld=%b rdy=%b want 0 1",
                     out_valid, in_ready);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL bp no-accept: rdy=%b want 1", in_ready);
            miscompares++;
        end
    endtask

    task automatic test_flush();
        logic seen;
        @(negedge clk);
        in_a     = 32'h1;
        in_mode  = MODE_XOR;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL flush busy: rdy=%b want 1", in_ready);
            miscompares++;
        end
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        vectors++;
        if (seen !== 1'b0) begin
            $display("FAIL flush discard: out_valid seen=%b want 0", seen);
            miscompares++;
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        seen = ~in_ready;
        repeat (10) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        vectors++;
        if (seen !== 1'b0) begin
            $display("FAIL flush idle: accepted/valid=%b want 0", seen);
            miscompares++;
        end
        run_op(MODE_XOR, 32'h0000_0003, "xor_after_flush");
    endtask

    task automatic test_async_reset();
        int n;
        @(negedge clk);
        in_a     = 32'h1234_5678;
        in_mode  = MODE_OR;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, out_bit, out_lzc} !== {3'b100, 6'd0}) begin
            $display("FAIL rst busy: rdy=%b vld=%b bit=%b lzc=%0d want 1 0 0 0",
                     in_ready, out_valid, out_bit, out_lzc);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_a     = 32'h0;
        in_mode  = MODE_NOR;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, out_bit, out_lzc} !== {3'b100, 6'd0}) begin
            $display("FAIL rst done: rdy=%b vld=%b bit=%b lzc=%0d want 1 0 0 0",
                     in_ready, out_valid, out_bit, out_lzc);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wide();
        run_wide(MODE_NOR, 64'h8000_0000_0000_0000, "w_nor_msb");
        run_wide(MODE_NOR, 64'h0000_0000_0000_0000, "w_nor_zero");
        run_wide(MODE_XOR, 64'h0000_0001_0000_0001, "w_xor_two");
        run_wide(MODE_AND, 64'hFFFF_FFFF_FFFF_FFFF, "w_and_ones");
    endtask

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_a        = '0;
        in_mode     = MODE_NOR;
        out_ready   = 1'b0;
        w_flush     = 1'b0;
        w_in_valid  = 1'b0;
        w_in_a      = '0;
        w_in_mode   = MODE_NOR;
        w_out_ready = 1'b0;
        test_reset();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_wide();
        vectors++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard: %0d left want 0", sb.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
